// File: rtl/hist_bank_scheduler_if.sv
// Histogram bank scheduler bus: frame/read handshake in, port-B RAM controls out.
interface hist_bank_scheduler_if #(
    parameter int unsigned DW = 16
);
    logic          frame_end;
    logic          rd_req;
    logic [7:0]    rd_addr;
    logic          rd_last;
    logic          area_flag;
    logic [7:0]    portb_addr;
    logic [31:0]   portb_rden_bus;
    logic [31:0]   portb_wren_bus;
    logic [DW-1:0] portb_wdata;
    logic          rd_grant;
    logic          busy;
    logic          clear_done;
    logic          overrun;

    // Mapping unit / frame source side
    modport master (
        output frame_end, rd_req, rd_addr, rd_last,
        input  area_flag, portb_addr, portb_rden_bus, portb_wren_bus,
               portb_wdata, rd_grant, busy, clear_done, overrun
    );

    // Scheduler side
    modport slave (
        input  frame_end, rd_req, rd_addr, rd_last,
        output area_flag, portb_addr, portb_rden_bus, portb_wren_bus,
               portb_wdata, rd_grant, busy, clear_done, overrun
    );
endinterface

// File: rtl/hist_bank_scheduler.sv
// Ping-pong histogram bank scheduler: swaps the accumulating RAM group on
// frame_end, serves port-B reads of the finished group, then zeroes it.
// Optional macro HBS_FRAME_PEND_EN: one-deep queue for a frame_end that
// arrives while busy (otherwise it is dropped and flags overrun).
module hist_bank_scheduler #(
    parameter int unsigned NBIN = 256,
    parameter int unsigned DW   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    hist_bank_scheduler_if.slave bus
);

    localparam int unsigned AW   = 8;
    localparam int unsigned NRAM = 32;

    localparam logic [AW-1:0]   CNT_LAST = AW'(NBIN - 1);
    localparam logic [NRAM-1:0] MASK_LO  = 32'h0000_FFFF;
    localparam logic [NRAM-1:0] MASK_HI  = 32'hFFFF_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        CLEAR = 2'd2
    } state_t;

    state_t          state_q,      state_d;
    logic            area_flag_q,  area_flag_d;
    logic            svc_grp_q,    svc_grp_d;
    logic [AW-1:0]   cnt_q,        cnt_d;
    logic            wrap_q,       wrap_d;
    logic [AW-1:0]   addr_q,       addr_d;
    logic [NRAM-1:0] rden_q,       rden_d;
    logic [NRAM-1:0] wren_q,       wren_d;
    logic [DW-1:0]   wdata_q,      wdata_d;
    logic            rd_grant_q,   rd_grant_d;
    logic            busy_q,       busy_d;
    logic            clear_done_q, clear_done_d;
    logic            overrun_q,    overrun_d;
`ifdef HBS_FRAME_PEND_EN
    logic            pend_q,       pend_d;
`endif

    logic [NRAM-1:0] svc_mask;
    logic            start;

    // RAM-enable mask of the group being serviced (never the accumulating one)
    always_comb begin
        svc_mask = svc_grp_q ? MASK_HI : MASK_LO;
    end

    // Next-state and registered-output computation
    always_comb begin
        state_d      = state_q;
        area_flag_d  = area_flag_q;
        svc_grp_d    = svc_grp_q;
        cnt_d        = cnt_q;
        wrap_d       = wrap_q;
        addr_d       = '0;
        rden_d       = '0;
        wren_d       = '0;
        wdata_d      = '0;
        clear_done_d = 1'b0;
        overrun_d    = overrun_q;
        start        = 1'b0;
`ifdef HBS_FRAME_PEND_EN
        pend_d       = pend_q;
`endif

        // frame_end while busy (includes the clear_done edge)
        if (bus.frame_end && (state_q != IDLE)) begin
`ifdef HBS_FRAME_PEND_EN
            if (!pend_q) begin
                pend_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
`else
            overrun_d = 1'b1;
`endif
        end

        case (state_q)
            IDLE: begin
`ifdef HBS_FRAME_PEND_EN
                start  = bus.frame_end || pend_q;
                pend_d = pend_q && bus.frame_end;
`else
                start  = bus.frame_end;
`endif
                if (start) begin
                    svc_grp_d   = area_flag_q;
                    area_flag_d = ~area_flag_q;
                    state_d     = READ;
                end
            end

            READ: begin
                if (bus.rd_req) begin
                    addr_d = bus.rd_addr;
                    rden_d = svc_mask;
                    if (bus.rd_last) begin
                        state_d = CLEAR;
                        cnt_d   = '0;
                        wrap_d  = 1'b0;
                    end
                end
            end

            CLEAR: begin
                if (wrap_q) begin
                    // last write already on the outputs: finish
                    state_d      = IDLE;
                    clear_done_d = 1'b1;
                    wrap_d       = 1'b0;
                end else begin
                    addr_d  = cnt_q;
                    wren_d  = svc_mask;
                    wdata_d = '0;
                    if (cnt_q == CNT_LAST) begin
                        cnt_d  = '0;
                        wrap_d = 1'b1;
                    end else begin
                        cnt_d = AW'(cnt_q + AW'(1));
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        rd_grant_d = (state_d == READ);
        busy_d     = (state_d != IDLE);
    end

    // State and output registers, synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            area_flag_q  <= 1'b0;
            svc_grp_q    <= 1'b0;
            cnt_q        <= '0;
            wrap_q       <= 1'b0;
            addr_q       <= '0;
            rden_q       <= '0;
            wren_q       <= '0;
            wdata_q      <= '0;
            rd_grant_q   <= 1'b0;
            busy_q       <= 1'b0;
            clear_done_q <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef HBS_FRAME_PEND_EN
            pend_q       <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            area_flag_q  <= area_flag_d;
            svc_grp_q    <= svc_grp_d;
            cnt_q        <= cnt_d;
            wrap_q       <= wrap_d;
            addr_q       <= addr_d;
            rden_q       <= rden_d;
            wren_q       <= wren_d;
            wdata_q      <= wdata_d;
            rd_grant_q   <= rd_grant_d;
            busy_q       <= busy_d;
            clear_done_q <= clear_done_d;
            overrun_q    <= overrun_d;
`ifdef HBS_FRAME_PEND_EN
            pend_q       <= pend_d;
`endif
        end
    end

    assign bus.area_flag      = area_flag_q;
    assign bus.portb_addr     = addr_q;
    assign bus.portb_rden_bus = rden_q;
    assign bus.portb_wren_bus = wren_q;
    assign bus.portb_wdata    = wdata_q;
    assign bus.rd_grant       = rd_grant_q;
    assign bus.busy           = busy_q;
    assign bus.clear_done     = clear_done_q;
    assign bus.overrun        = overrun_q;

endmodule

// File: tb/tb_hist_bank_scheduler.sv
// Bench for hist_bank_scheduler: vector table, directed corner sequences and
// random traffic, all checked against a cycle-count based reference model.
module tb_hist_bank_scheduler;

    localparam int unsigned NBIN = 256;
    localparam int unsigned DW   = 16;
    localparam int M_IDLE  = 0;
    localparam int M_READ  = 1;
    localparam int M_CLEAR = 2;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    hist_bank_scheduler_if #(.DW(DW)) bus ();

    hist_bank_scheduler #(.NBIN(NBIN), .DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model state
    int          m_mode = M_IDLE;
    logic        m_area = 1'b0;
    logic        m_svc  = 1'b0;
    logic        m_pend = 1'b0;
    logic        m_ovr  = 1'b0;
    int          m_cyc  = 0;
    int          m_clr_first = 0;
    logic [7:0]  e_addr;
    logic [31:0] e_rden;
    logic [31:0] e_wren;
    logic        e_done;
    logic        e_busy;
    logic        e_grant;

    typedef struct {
        logic        rst;
        logic        fe;
        logic        req;
        logic [7:0]  addr;
        logic        last;
        logic        e_area;
        logic        e_busy;
        logic        e_grant;
        logic [7:0]  e_addr;
        logic [31:0] e_rden;
    } vec_t;

    vec_t vecs [7];

    function automatic logic [31:0] grp_mask(input logic g);
        return g ? 32'hFFFF_0000 : 32'h0000_FFFF;
    endfunction

    function automatic vec_t mk(input logic r, input logic fe, input logic rq,
                                input logic [7:0] a, input logic l,
                                input logic ea, input logic eb, input logic eg,
                                input logic [7:0] ead, input logic [31:0] er);
        vec_t v;
        v.rst = r; v.fe = fe; v.req = rq; v.addr = a; v.last = l;
        v.e_area = ea; v.e_busy = eb; v.e_grant = eg; v.e_addr = ead; v.e_rden = er;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s @%0t actual=0x%0h required=0x%0h", name, $time, act, exp);
        end
    endtask

    // model of one clock edge, derived from the behavioural rules
    task automatic model_edge(input logic r, input logic fe, input logic rq,
                              input logic [7:0] a, input logic l);
        int   k;
        logic go;
        m_cyc++;
        e_addr = '0; e_rden = '0; e_wren = '0; e_done = 1'b0;
        if (r) begin
            m_mode = M_IDLE; m_area = 1'b0; m_svc = 1'b0; m_pend = 1'b0; m_ovr = 1'b0;
        end else begin
            if (fe && m_mode != M_IDLE) begin
`ifdef HBS_FRAME_PEND_EN
                if (!m_pend) m_pend = 1'b1;
                else         m_ovr  = 1'b1;
`else
                m_ovr = 1'b1;
`endif
            end
            if (m_mode == M_IDLE) begin
`ifdef HBS_FRAME_PEND_EN
                go = fe || m_pend;
                m_pend = m_pend && fe;
`else
                go = fe;
`endif
                if (go) begin
                    m_svc  = m_area;
                    m_area = ~m_area;
                    m_mode = M_READ;
                end
            end else if (m_mode == M_READ) begin
                if (rq) begin
                    e_addr = a;
                    e_rden = grp_mask(m_svc);
                    if (l) begin
                        m_mode = M_CLEAR;
                        m_clr_first = m_cyc + 1;
                    end
                end
            end else begin
                k = m_cyc - m_clr_first;
                if (k < int'(NBIN)) begin
                    e_addr = 8'(k);
                    e_wren = grp_mask(m_svc);
                end else begin
                    e_done = 1'b1;
                    m_mode = M_IDLE;
                end
            end
        end
        e_busy  = (m_mode != M_IDLE);
        e_grant = (m_mode == M_READ);
    endtask

    // apply inputs for one cycle, then compare every output with the model
    task automatic step(input logic r, input logic fe, input logic rq,
                        input logic [7:0] a, input logic l);
        rst = r;
        bus.frame_end = fe;
        bus.rd_req    = rq;
        bus.rd_addr   = a;
        bus.rd_last   = l;
        @(posedge clk);
        model_edge(r, fe, rq, a, l);
        #1;
        chk("mdl_area",  32'(bus.area_flag),      32'(m_area));
        chk("mdl_busy",  32'(bus.busy),           32'(e_busy));
        chk("mdl_grant", 32'(bus.rd_grant),       32'(e_grant));
        chk("mdl_addr",  32'(bus.portb_addr),     32'(e_addr));
        chk("mdl_rden",  bus.portb_rden_bus,      e_rden);
        chk("mdl_wren",  bus.portb_wren_bus,      e_wren);
        chk("mdl_wdata", 32'(bus.portb_wdata),    32'd0);
        chk("mdl_done",  32'(bus.clear_done),     32'(e_done));
        chk("mdl_ovr",   32'(bus.overrun),        32'(m_ovr));
    endtask

    task automatic idle_step();
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    // step idle until the write to target is on the outputs (bounded)
    task automatic wait_write(input logic [7:0] target);
        int n;
        n = 0;
        while (!(bus.portb_wren_bus != 32'd0 && bus.portb_addr == target) && n < 400) begin
            idle_step();
            n++;
        end
        chk("wait_write_timeout", 32'(n >= 400), 32'd0);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (bus.clear_done !== 1'b1 && n < 400) begin
            idle_step();
            n++;
        end
        chk("wait_done_timeout", 32'(n >= 400), 32'd0);
    endtask

    initial begin
        int dones;
        checks   = 0;
        failures = 0;
        rst = 1'b1;
        bus.frame_end = 1'b0;
        bus.rd_req    = 1'b0;
        bus.rd_addr   = '0;
        bus.rd_last   = 1'b0;

        // reset, frame start, reads, ignored rd_last
        vecs[0] = mk(1, 0, 0, 8'h00, 0,  0, 0, 0, 8'h00, 32'h0000_0000);
        vecs[1] = mk(0, 0, 0, 8'h00, 0,  0, 0, 0, 8'h00, 32'h0000_0000);
        vecs[2] = mk(0, 1, 0, 8'h00, 0,  1, 1, 1, 8'h00, 32'h0000_0000);
        vecs[3] = mk(0, 0, 1, 8'h3C, 0,  1, 1, 1, 8'h3C, 32'h0000_FFFF);
        vecs[4] = mk(0, 0, 0, 8'h55, 0,  1, 1, 1, 8'h00, 32'h0000_0000);
        vecs[5] = mk(0, 0, 1, 8'hFF, 0,  1, 1, 1, 8'hFF, 32'h0000_FFFF);
        vecs[6] = mk(0, 0, 0, 8'h11, 1,  1, 1, 1, 8'h00, 32'h0000_0000);

        for (int i = 0; i < 7; i++) begin
            step(vecs[i].rst, vecs[i].fe, vecs[i].req, vecs[i].addr, vecs[i].last);
            chk($sformatf("vec%0d_area", i),  32'(bus.area_flag),  32'(vecs[i].e_area));
            chk($sformatf("vec%0d_busy", i),  32'(bus.busy),       32'(vecs[i].e_busy));
            chk($sformatf("vec%0d_grant", i), 32'(bus.rd_grant),   32'(vecs[i].e_grant));
            chk($sformatf("vec%0d_addr", i),  32'(bus.portb_addr), 32'(vecs[i].e_addr));
            chk($sformatf("vec%0d_rden", i),  bus.portb_rden_bus,  vecs[i].e_rden);
        end

        // final read then full clear of group 0
        step(1'b0, 1'b0, 1'b1, 8'h07, 1'b1);
        chk("last_addr",  32'(bus.portb_addr), 32'h07);
        chk("last_grant", 32'(bus.rd_grant),   32'd0);
        dones = 0;
        for (int i = 0; i < 256; i++) begin
            idle_step();
            chk("clr_addr", 32'(bus.portb_addr), 32'(i));
            chk("clr_wren", bus.portb_wren_bus, 32'h0000_FFFF);
            chk("clr_rden", bus.portb_rden_bus, 32'd0);
            chk("clr_busy", 32'(bus.busy), 32'd1);
            if (bus.clear_done) dones++;
        end
        idle_step();
        chk("clr_done_pulse", 32'(bus.clear_done), 32'd1);
        chk("clr_done_busy",  32'(bus.busy), 32'd0);
        chk("clr_done_wren",  bus.portb_wren_bus, 32'd0);
        idle_step();
        chk("clr_done_single", 32'(bus.clear_done), 32'd0);
        chk("clr_done_early",  32'(dones), 32'd0);

        // second frame services group 1; busy frame_end at cnt 100
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        chk("f2_area", 32'(bus.area_flag), 32'd0);
        step(1'b0, 1'b0, 1'b1, 8'h20, 1'b0);
        chk("f2_rden", bus.portb_rden_bus, 32'hFFFF_0000);
        step(1'b0, 1'b0, 1'b1, 8'h21, 1'b1);
        wait_write(8'd99);
        chk("f2_wren", bus.portb_wren_bus, 32'hFFFF_0000);
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        chk("busy_fe_addr", 32'(bus.portb_addr), 32'd100);
`ifdef HBS_FRAME_PEND_EN
        chk("busy_fe_ovr", 32'(bus.overrun), 32'd0);
`else
        chk("busy_fe_ovr", 32'(bus.overrun), 32'd1);
`endif
        chk("busy_fe_area", 32'(bus.area_flag), 32'd0);
        wait_done();
        chk("f2_done_busy", 32'(bus.busy), 32'd0);
        idle_step();
`ifdef HBS_FRAME_PEND_EN
        chk("pend_start_busy", 32'(bus.busy), 32'd1);
        chk("pend_start_area", 32'(bus.area_flag), 32'd1);
`else
        chk("drop_busy", 32'(bus.busy), 32'd0);
        chk("drop_area", 32'(bus.area_flag), 32'd0);
`endif

        // reset in the middle of a clear
        if (m_mode == M_IDLE) step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b0, 1'b1, 8'h40, 1'b1);
        wait_write(8'd49);
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        chk("rst_addr", 32'(bus.portb_addr), 32'd0);
        chk("rst_wren", bus.portb_wren_bus, 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_area", 32'(bus.area_flag), 32'd0);
        chk("rst_ovr",  32'(bus.overrun), 32'd0);
        dones = 0;
        for (int i = 0; i < 300; i++) begin
            idle_step();
            if (bus.clear_done) dones++;
        end
        chk("rst_no_done", 32'(dones), 32'd0);

        // random traffic against the model
        for (int i = 0; i < 5000; i++) begin
            step(1'($urandom_range(0, 599) == 0),
                 1'($urandom_range(0, 39) == 0),
                 1'($urandom_range(0, 1)),
                 8'($urandom),
                 1'($urandom_range(0, 24) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hist_bank_scheduler.md
HIST_BANK_SCHEDULER -- requirements
Module: hist_bank_scheduler

Interface
REQ-001 Parameter NBIN, default 256, meaning bins per histogram RAM; the address width is fixed at 8 bits.
REQ-002 Parameter DW, default 16, meaning bin data width.
REQ-003 Port clk, input, 1, meaning the single clock; all logic on its rising edge.
REQ-004 Port rst, input, 1, meaning reset: synchronous, active-high.
REQ-005 Port frame_end, input, 1, meaning a one-cycle pulse: accumulation into the active bank group is finished.
REQ-006 Port rd_req, input, 1, meaning the mapping unit requests a port-B read this cycle.
REQ-007 Port rd_addr, input, 8, meaning the requested bin address.
REQ-008 Port rd_last, input, 1, meaning this rd_req is the final read of the frame.
REQ-009 Port area_flag, output, 1, meaning the accumulating group: 0 = RAMs 0-15, 1 = RAMs 16-31.
REQ-010 Port portb_addr, output, 8, meaning the port-B address to all 32 RAMs.
REQ-011 Port portb_rden_bus, output, 32, meaning per-RAM port-B read enables.
REQ-012 Port portb_wren_bus, output, 32, meaning per-RAM port-B write enables.
REQ-013 Port portb_wdata, output, DW, meaning port-B write data.
REQ-014 Port rd_grant, output, 1, meaning reads are accepted this cycle.
REQ-015 Port busy, output, 1, meaning the state is not IDLE.
REQ-016 Port clear_done, output, 1, meaning a one-cycle pulse: the service group is fully zeroed.
REQ-017 Port overrun, output, 1, meaning a sticky flag set when frame_end arrived while the block could not accept it.

Function
REQ-018 The FSM SHALL have exactly three states: IDLE, READ and CLEAR.
REQ-019 In IDLE, on frame_end, the block SHALL latch svc_grp = area_flag, toggle area_flag and enter READ, all on the same edge.
REQ-020 In READ, rd_grant SHALL be 1 (level, combinational from state), and each cycle with rd_req SHALL register portb_addr = rd_addr and portb_rden_bus = the 16-bit mask of svc_grp; outputs follow the request with 1-cycle latency.
REQ-021 In READ, rd_req with rd_last SHALL complete that read and move the FSM to CLEAR on the same edge; rd_last without rd_req SHALL be ignored.
REQ-022 Outside READ, rd_req SHALL be ignored and rd_grant SHALL be 0.
REQ-023 CLEAR SHALL last exactly NBIN cycles with an 8-bit counter cnt running 0..255; each cycle it SHALL register portb_addr = cnt, portb_wren_bus = the svc_grp mask, portb_wdata = 0 and portb_rden_bus = 0.
REQ-024 The svc_grp mask SHALL be 32'h0000_FFFF when svc_grp = 0 and 32'hFFFF_0000 when svc_grp = 1; the accumulating group's enables SHALL never be asserted by this block.
REQ-025 On the cycle after the cnt = 255 write is presented on the outputs, clear_done SHALL pulse for 1 cycle and the FSM SHALL return to IDLE; cnt wraps to 0 and is not reused.
REQ-026 When not driving an access, portb_addr, the enable buses and portb_wdata SHALL be 0; no output is ever high-impedance.
REQ-027 frame_end in READ or CLEAR, including the cycle of the clear_done edge, SHALL be handled per REQ-031/REQ-032.
REQ-028 The overrun flag SHALL clear only on rst.

Reset
REQ-029 While rst = 1, on each clk edge: state = IDLE, area_flag = 0, svc_grp = 0, cnt = 0, all output buses = 0, clear_done = 0, overrun = 0, and any pending request is discarded.
REQ-030 An rst mid-READ or mid-CLEAR SHALL abort the sequence with no clear_done pulse.

Configuration
REQ-031 With HBS_FRAME_PEND_EN defined, one pending slot SHALL latch a busy frame_end and sets no overrun; on return to IDLE the pending request is serviced on the next cycle as in REQ-019; a frame_end while the slot is already full SHALL set overrun and is dropped.
REQ-032 Without HBS_FRAME_PEND_EN, a busy frame_end SHALL be dropped, SHALL set overrun, and area_flag SHALL not toggle.

Verification
REQ-033 Scenario 1: rst, then frame_end -> area_flag = 1, busy = 1 the next cycle, rd_grant = 1.
REQ-034 Scenario 2: in READ, rd_req with rd_addr = 0x3C -> the next cycle portb_addr = 0x3C and portb_rden_bus = 32'h0000_FFFF.
REQ-035 Scenario 3: rd_req with rd_last -> 256 cycles of portb_wren_bus = 32'h0000_FFFF with addr 0..255 and wdata 0, then a single clear_done pulse and busy = 0.
REQ-036 Scenario 4: a second frame cycle -> svc_grp = 1, masks = 32'hFFFF_0000, area_flag returns to 0.
REQ-037 Scenario 5: frame_end at cnt = 100 -> overrun = 1 without the macro; with the macro, IDLE lasts 1 cycle and then READ starts with area_flag toggled.
REQ-038 Scenario 6: rst at cnt = 50 -> all outputs 0 the next cycle and no clear_done pulse.
